ape_accumulator: RTL

- Accumulation stage directly downstream of the MPE-to-APE crossbar.
- Each cycle, adds the crossbar's per-output-channel partial tiles into per-channel accumulator tiles, gated by channel_en.
- At the end of a tile pass (in_last), freezes the results and drains them one output channel per beat over a valid/ready stream to the output writer.
- Decouples the MPE array from the output writer: new passes stall while a drain is in progress.

---
 rtl/ape_accumulator_if.sv | 32 +++
 rtl/ape_accumulator.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ape_accumulator_if.sv
// Stream bundle between the crossbar, the APE accumulation stage and the output writer.
// master = crossbar/writer side, slave = accumulator side.
interface ape_accumulator_if #(
  parameter int OUTPUT_CHANNEL = 8,
  parameter int OUTPUT_HEIGHT  = 4,
  parameter int OUTPUT_WIDTH   = 4,
  parameter int OUT_BIN_LEN    = 16,
  parameter int ACC_LEN        = 24
);
  localparam int CH_W = (OUTPUT_CHANNEL > 1) ? $clog2(OUTPUT_CHANNEL) : 1;

  logic [OUTPUT_CHANNEL*OUTPUT_HEIGHT*OUTPUT_WIDTH*OUT_BIN_LEN-1:0] APE_inputs;
  logic [OUTPUT_CHANNEL-1:0]                                        channel_en;
  logic                                                             in_valid;
  logic                                                             in_last;
  logic                                                             in_ready;
  logic                                                             out_valid;
  logic                                                             out_ready;
  logic [CH_W-1:0]                                                  out_channel;
  logic [OUTPUT_HEIGHT*OUTPUT_WIDTH*ACC_LEN-1:0]                    out_tile;
  logic                                                             out_last;

  modport master (
    output APE_inputs, channel_en, in_valid, in_last, out_ready,
    input  in_ready, out_valid, out_channel, out_tile, out_last
  );

  modport slave (
    input  APE_inputs, channel_en, in_valid, in_last, out_ready,
    output in_ready, out_valid, out_channel, out_tile, out_last
  );
endinterface

// File: rtl/ape_accumulator.sv
// Per-channel saturating tile accumulator that drains one channel per beat after in_last.
// Optional macro APE_RELU_EN: clamp drained elements at zero (stored sums untouched).
module ape_accumulator #(
  parameter int OUTPUT_CHANNEL = 8,
  parameter int OUTPUT_HEIGHT  = 4,
  parameter int OUTPUT_WIDTH   = 4,
  parameter int OUT_BIN_LEN    = 16,
  parameter int ACC_LEN        = 24
) (
  input logic              clk,
  input logic              rst_n,
  ape_accumulator_if.slave bus
);
  localparam int TILE = OUTPUT_HEIGHT * OUTPUT_WIDTH;
  localparam int CH_W = (OUTPUT_CHANNEL > 1) ? $clog2(OUTPUT_CHANNEL) : 1;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam logic signed [ACC_LEN-1:0] ACC_MAX = {1'b0, {(ACC_LEN-1){1'b1}}};
  localparam logic signed [ACC_LEN-1:0] ACC_MIN = {1'b1, {(ACC_LEN-1){1'b0}}};

  logic [0:0]                 state_q, state_d;
  logic [CH_W-1:0]            idx_q, idx_d;
  logic signed [ACC_LEN-1:0]  acc_q [OUTPUT_CHANNEL][TILE];
  logic signed [ACC_LEN-1:0]  acc_d [OUTPUT_CHANNEL][TILE];
  logic                       idx_last;

  // One guard bit is enough: the sum of an ACC_LEN value and a narrower one fits ACC_LEN+1.
  function automatic logic signed [ACC_LEN-1:0] sat_add(
    input logic signed [ACC_LEN-1:0]     a,
    input logic signed [OUT_BIN_LEN-1:0] b
  );
    logic signed [ACC_LEN:0] s;
    s = {a[ACC_LEN-1], a} + {{(ACC_LEN+1-OUT_BIN_LEN){b[OUT_BIN_LEN-1]}}, b};
    if (s[ACC_LEN] != s[ACC_LEN-1])
      sat_add = s[ACC_LEN] ? ACC_MIN : ACC_MAX;
    else
      sat_add = s[ACC_LEN-1:0];
  endfunction

`ifdef APE_RELU_EN
  function automatic logic signed [ACC_LEN-1:0] relu(input logic signed [ACC_LEN-1:0] x);
    relu = x[ACC_LEN-1] ? '0 : x;
  endfunction
`endif

  assign idx_last = (idx_q == CH_W'(OUTPUT_CHANNEL - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    case (state_q)
      ST_ACCUM: begin
        if (bus.in_valid) begin
          // Disabled lanes may float, so they are never read into the adder.
          for (int ch = 0; ch < OUTPUT_CHANNEL; ch++) begin
            if (bus.channel_en[ch]) begin
              for (int e = 0; e < TILE; e++) begin
                acc_d[ch][e] = sat_add(acc_q[ch][e],
                  $signed(bus.APE_inputs[(ch*TILE+e)*OUT_BIN_LEN +: OUT_BIN_LEN]));
              end
            end
          end
          if (bus.in_last) begin
            state_d = ST_DRAIN;
            idx_d   = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (bus.out_ready) begin
          for (int e = 0; e < TILE; e++) acc_d[idx_q][e] = '0;
          if (idx_last) begin
            state_d = ST_ACCUM;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CH_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_ACCUM;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      idx_q   <= '0;
      for (int ch = 0; ch < OUTPUT_CHANNEL; ch++)
        for (int e = 0; e < TILE; e++)
          acc_q[ch][e] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.in_ready    = (state_q == ST_ACCUM);
  assign bus.out_valid   = (state_q == ST_DRAIN);
  assign bus.out_channel = idx_q;
  assign bus.out_last    = (state_q == ST_DRAIN) && idx_last;

  // The drained tile is a straight read of the frozen accumulator, so it holds under backpressure.
  always_comb begin
    bus.out_tile = '0;
    if (state_q == ST_DRAIN) begin
      for (int e = 0; e < TILE; e++) begin
`ifdef APE_RELU_EN
        bus.out_tile[e*ACC_LEN +: ACC_LEN] = relu(acc_q[idx_q][e]);
`else
        bus.out_tile[e*ACC_LEN +: ACC_LEN] = acc_q[idx_q][e];
`endif
      end
    end
  end
endmodule
